// File: rtl/uart_rx_digit_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_digit_pkg
// Shared definitions for the UART digit receiver:
//   - default clock / baud settings
//   - receiver FSM state encoding (3 bits)
//   - ASCII range limits for the digit decoder
// No ports; imported with `import uart_rx_digit_pkg::*;`.
// -----------------------------------------------------------------------------
package uart_rx_digit_pkg;

    localparam int DEFAULT_CLK_FREQ_HZ = 100000000;
    localparam int DEFAULT_BAUD_RATE   = 115200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_UF = 8'h46;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LF = 8'h66;

endpackage

// File: rtl/uart_rx_digit_ascii_to_nibble.sv
// -----------------------------------------------------------------------------
// uart_rx_digit_ascii_to_nibble
// Combinational ASCII character -> 4-bit digit value decoder.
// Optional feature macro: UART_RX_HEX_DIGIT_EN
//   undefined : only '0'..'9' are valid (values 0..9)
//   defined   : 'A'..'F' and 'a'..'f' are also valid (values 10..15)
// Ports:
//   code    in  8  received character
//   valid   out 1  character is a legal digit
//   nibble  out 4  digit value (0 when not valid)
// -----------------------------------------------------------------------------
module uart_rx_digit_ascii_to_nibble
    import uart_rx_digit_pkg::*;
(
    input  logic [7:0] code,
    output logic       valid,
    output logic [3:0] nibble
);

`ifdef UART_RX_HEX_DIGIT_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif

    always_comb begin
        valid  = 1'b0;
        nibble = 4'd0;
        if (code >= ASCII_0 && code <= ASCII_9) begin
            valid  = 1'b1;
            nibble = 4'(code - ASCII_0);
        end else if (HEX_EN && code >= ASCII_UA && code <= ASCII_UF) begin
            valid  = 1'b1;
            nibble = 4'(code - ASCII_UA + 8'd10);
        end else if (HEX_EN && code >= ASCII_LA && code <= ASCII_LF) begin
            valid  = 1'b1;
            nibble = 4'(code - ASCII_LA + 8'd10);
        end
    end

endmodule

// File: rtl/uart_rx_digit.sv
// -----------------------------------------------------------------------------
// uart_rx_digit
// 8N1 UART receiver that decodes ASCII digit characters into a 4-bit value
// for the 7-segment digit shift stage.
// Optional feature macro: UART_RX_HEX_DIGIT_EN (hex letters accepted, see
// uart_rx_digit_ascii_to_nibble).
// Parameters:
//   CLK_FREQ_HZ  system clock in Hz
//   BAUD_RATE    serial bit rate; CLK_FREQ_HZ/BAUD_RATE must be >= 4
// Ports:
//   clk            in  1  system clock, rising edge
//   rst            in  1  asynchronous active-high reset
//   rx             in  1  asynchronous serial line, idles high
//   digit_data     out 4  last accepted digit, held until the next accept
//   digit_strobe   out 1  toggles once per accepted digit
//   frame_err      out 1  one-cycle pulse when the stop bit is low
//   char_rejected  out 1  one-cycle pulse for a well-framed non-digit byte
//   rx_busy        out 1  high whenever the FSM is not IDLE
//   fsm_state      out 3  current FSM state (rx_state_t encoding), debug
//
// Digit handshake (level-change protocol): there is no ready. Each accept
// updates digit_data and inverts digit_strobe on the same clock edge. The
// consumer registers the strobe once and treats any difference between its
// delayed copy and the live strobe as "one new digit"; by then digit_data has
// been stable for a cycle. digit_data changes on no other edge. Digits are at
// least one frame apart, so the consumer never misses a level change.
// -----------------------------------------------------------------------------
module uart_rx_digit
    import uart_rx_digit_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEFAULT_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] digit_data,
    output logic       digit_strobe,
    output logic       frame_err,
    output logic       char_rejected,
    output logic       rx_busy,
    output logic [2:0] fsm_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int TICK_W       = $clog2(CLKS_PER_BIT);

    // Half-bit point lands the START sample mid-bit; every later sample is
    // then a whole bit period on.
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_rate_check
            $error("uart_rx_digit: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    // Two-flop synchroniser; resets to the idle line level.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    rx_state_t         state, state_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic [2:0]        bit_cnt, bit_n;
    logic [7:0]        shreg, shreg_n;
    logic              accept;
    logic              frame_err_n;
    logic              reject_n;
    logic              dec_valid;
    logic [3:0]        dec_nibble;

    // Decoder sees the complete byte during the stop-sample cycle.
    uart_rx_digit_ascii_to_nibble u_dec (
        .code   (shreg),
        .valid  (dec_valid),
        .nibble (dec_nibble)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_n      = tick;
        bit_n       = bit_cnt;
        shreg_n     = shreg;
        accept      = 1'b0;
        frame_err_n = 1'b0;
        reject_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    tick_n  = '0;
                end
            end
            ST_START: begin
                if (tick == HALF_LAST) begin
                    tick_n = '0;
                    if (!rx_s) begin
                        state_n = ST_DATA;
                        bit_n   = '0;
                    end else begin
                        // Start bit vanished before mid-bit: treat as noise.
                        state_n = ST_IDLE;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            ST_DATA: begin
                if (tick == BIT_LAST) begin
                    tick_n  = '0;
                    shreg_n = {rx_s, shreg[7:1]};   // LSB arrives first
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            ST_STOP: begin
                if (tick == BIT_LAST) begin
                    tick_n = '0;
                    if (rx_s) begin
                        state_n = ST_IDLE;
                        if (dec_valid) begin
                            accept = 1'b1;
                        end else begin
                            reject_n = 1'b1;
                        end
                    end else begin
                        state_n     = ST_BREAK;
                        frame_err_n = 1'b1;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            ST_BREAK: begin
                // Stay here while the line is held low so a break is not
                // mistaken for a stream of start bits.
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_data    <= 4'd0;
            digit_strobe  <= 1'b0;
            frame_err     <= 1'b0;
            char_rejected <= 1'b0;
        end else begin
            frame_err     <= frame_err_n;
            char_rejected <= reject_n;
            if (accept) begin
                digit_data   <= dec_nibble;
                digit_strobe <= ~digit_strobe;
            end
        end
    end

    assign rx_busy   = (state != ST_IDLE);
    assign fsm_state = state;

endmodule
